// File: rtl/seq_div_pkg.sv
// Shared constants and FSM encoding for the 8-by-4 sequential restoring divider.
package seq_div_pkg;

    localparam int unsigned DW = 8;
    localparam int unsigned VW = 4;

    localparam logic [DW-1:0] DBZ_QUOT = 8'hFF;
    localparam logic [VW-1:0] DBZ_REM  = 4'h0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_div8by4_if.sv
// Operand and result handshakes of the divider; slave is the divider, master the client.
interface seq_div8by4_if;
    import seq_div_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/seq_div8by4_div_step.sv
// One restoring-division step: shift the next dividend bit into R, subtract D if it fits.
module div_step
    import seq_div_pkg::*;
(
    input  logic [VW:0]   rem_i,
    input  logic          q_msb_i,
    input  logic [VW-1:0] div_i,
    output logic [VW:0]   rem_o,
    output logic          q_bit_o
);

    logic [VW:0] trial;
    logic [VW:0] div_ext;

    always_comb begin
        trial   = {rem_i[VW-1:0], q_msb_i};
        div_ext = {1'b0, div_i};
        // rem_i[VW] is always 0 while R < D holds; an overflowed trial would always fit.
        q_bit_o = rem_i[VW] | (trial >= div_ext);
        rem_o   = q_bit_o ? (trial - div_ext) : trial;
    end

endmodule

// File: rtl/seq_div8by4.sv
// Sequential 8-by-4 restoring divider: one quotient bit per clock, MSB first.
module seq_div8by4
    import seq_div_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    seq_div8by4_if.slave  bus
);

    state_e        state_q;
    logic [DW-1:0] q_q;
    logic [VW:0]   r_q;
    logic [VW-1:0] d_q;
    logic [2:0]    cnt_q;
    logic          dbz_q;
    logic          in_ready_q;
    logic          out_valid_q;

    logic [VW:0]   step_rem;
    logic          step_bit;

    div_step u_div_step (
        .rem_i   (r_q),
        .q_msb_i (q_q[DW-1]),
        .div_i   (d_q),
        .rem_o   (step_rem),
        .q_bit_o (step_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            q_q         <= '0;
            r_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            dbz_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        d_q        <= bus.divisor;
                        r_q        <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        if (bus.divisor == '0) begin
                            // Q and R double as the result registers, so preload the DBZ result.
                            q_q         <= DBZ_QUOT;
                            r_q         <= {1'b0, DBZ_REM};
                            dbz_q       <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            q_q     <= bus.dividend;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_q   <= step_rem;
                    q_q   <= {q_q[DW-2:0], step_bit};
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        dbz_q       <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.quotient    = q_q;
    assign bus.remainder   = r_q[VW-1:0];
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div8by4.sv
// Self-checking bench for seq_div8by4 against a plain-arithmetic division model.
module tb_seq_div8by4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;

    seq_div8by4_if dif ();

    seq_div8by4 dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // {dbz, quotient, remainder}
    function automatic logic [12:0] ref_div(input int a, input int b);
        if (b == 0) return {1'b1, 8'hFF, 4'h0};
        return {1'b0, 8'(a / b), 4'(a % b)};
    endfunction

    // Called just after the accept edge; returns edges until out_valid is seen.
    task automatic wait_valid(output int n);
        n = 0;
        @(negedge clk);
        while (!dif.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic handshake(input string tag);
        dif.out_ready = 1'b1;
        dif.in_valid  = 1'b0;
        @(posedge clk);
        #1 dif.out_ready = 1'b0;
        @(negedge clk);
        check_eq({tag, "_post_ovalid"}, 32'(dif.out_valid), 32'd0);
        check_eq({tag, "_post_irdy"}, 32'(dif.in_ready), 32'd1);
    endtask

    // Starts and ends at a negedge with the DUT idle.
    task automatic run_div(input logic [7:0] a, input logic [3:0] b, input logic [12:0] exp,
                           input int hold, input bit scramble, input string tag);
        int n;
        check_eq({tag, "_irdy"}, 32'(dif.in_ready), 32'd1);
        dif.dividend = a;
        dif.divisor  = b;
        dif.in_valid = 1'b1;
        @(posedge clk);
        #1 dif.in_valid = 1'b0;
        if (scramble) begin
            dif.dividend = 8'($urandom);
            dif.divisor  = 4'($urandom);
        end
        wait_valid(n);
        check_eq({tag, "_lat"}, 32'(n), exp[12] ? 32'd0 : 32'd8);
        check_eq({tag, "_quot"}, 32'(dif.quotient), 32'(exp[11:4]));
        check_eq({tag, "_rem"}, 32'(dif.remainder), 32'(exp[3:0]));
        check_eq({tag, "_dbz"}, 32'(dif.div_by_zero), 32'(exp[12]));
        check_eq({tag, "_busy"}, 32'(dif.in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            if (scramble) begin
                dif.in_valid = 1'b1;
                dif.dividend = 8'($urandom);
                dif.divisor  = 4'($urandom);
            end
            @(negedge clk);
            check_eq({tag, "_hold_q"}, 32'(dif.quotient), 32'(exp[11:4]));
            check_eq({tag, "_hold_r"}, 32'(dif.remainder), 32'(exp[3:0]));
            check_eq({tag, "_hold_v"}, 32'(dif.out_valid), 32'd1);
            check_eq({tag, "_hold_irdy"}, 32'(dif.in_ready), 32'd0);
        end
        handshake(tag);
    endtask

    initial begin
        int n;
        n_checks      = 0;
        n_err         = 0;
        rst           = 1'b1;
        dif.in_valid  = 1'b0;
        dif.out_ready = 1'b0;
        dif.dividend  = '0;
        dif.divisor   = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_irdy", 32'(dif.in_ready), 32'd1);
        check_eq("rst_ovalid", 32'(dif.out_valid), 32'd0);
        check_eq("rst_quot", 32'(dif.quotient), 32'd0);
        check_eq("rst_rem", 32'(dif.remainder), 32'd0);
        check_eq("rst_dbz", 32'(dif.div_by_zero), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_div(8'd200, 4'd13, ref_div(200, 13), 0, 1'b0, "d200_13");

        // Back-to-back: in_valid stays high; second pair must wait for the first handshake.
        dif.dividend = 8'd255;
        dif.divisor  = 4'd1;
        dif.in_valid = 1'b1;
        @(posedge clk);
        #1 dif.dividend = 8'd7;
        dif.divisor = 4'd9;
        wait_valid(n);
        check_eq("b2b1_lat", 32'(n), 32'd8);
        check_eq("b2b1_quot", 32'(dif.quotient), 32'd255);
        check_eq("b2b1_rem", 32'(dif.remainder), 32'd0);
        dif.out_ready = 1'b1;
        @(posedge clk);
        #1 dif.out_ready = 1'b0;
        @(negedge clk);
        check_eq("b2b_gap_irdy", 32'(dif.in_ready), 32'd1);
        check_eq("b2b_gap_ovalid", 32'(dif.out_valid), 32'd0);
        @(posedge clk);
        #1 dif.in_valid = 1'b0;
        wait_valid(n);
        check_eq("b2b2_lat", 32'(n), 32'd8);
        check_eq("b2b2_quot", 32'(dif.quotient), 32'd0);
        check_eq("b2b2_rem", 32'(dif.remainder), 32'd7);
        handshake("b2b2");

        run_div(8'd100, 4'd0, ref_div(100, 0), 1, 1'b0, "dbz");
        run_div(8'd100, 4'd3, ref_div(100, 3), 0, 1'b0, "after_dbz");
        run_div(8'd143, 4'd11, ref_div(143, 11), 6, 1'b1, "bp143_11");

        // Abort mid-computation with an asynchronous reset.
        dif.dividend = 8'd200;
        dif.divisor  = 4'd13;
        dif.in_valid = 1'b1;
        @(posedge clk);
        #1 dif.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("abort_irdy", 32'(dif.in_ready), 32'd1);
        check_eq("abort_ovalid", 32'(dif.out_valid), 32'd0);
        check_eq("abort_quot", 32'(dif.quotient), 32'd0);
        check_eq("abort_rem", 32'(dif.remainder), 32'd0);
        check_eq("abort_dbz", 32'(dif.div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check_eq("abort_no_ovalid", 32'(dif.out_valid), 32'd0);
        end
        run_div(8'd50, 4'd7, ref_div(50, 7), 0, 1'b0, "d50_7");

        // Round trip through a 4x4 multiplier: p = a*b, expect a back with zero remainder.
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                run_div(8'(a * b), 4'(b), {1'b0, 8'(a), 4'h0}, 0, 1'b0, "rt");
            end
        end

        for (int i = 0; i < 150; i++) begin
            int a;
            int b;
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 15));
            run_div(8'(a), 4'(b), ref_div(a, b), int'($urandom_range(0, 3)), 1'($urandom),
                    "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
